// File: rtl/register_file_mp.sv
// Multi-ported register file with per-register reservation (pending) bits,
// same-cycle write-to-read bypass and a self-timed full-file clear sweep.
module register_file_mp #(
    parameter int PROC_DATA_WIDTH        = 16,
    parameter int PROC_REGFILE_LOG2_DEEP = 5,
    parameter int NUM_REGISTERS          = 32,
    parameter int NUM_WR_PORTS           = 2,
    parameter int NUM_RD_PORTS           = 4,
    parameter int ZERO_REG               = 1
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic [NUM_WR_PORTS-1:0]                          write_en_i,
    input  logic [NUM_WR_PORTS*PROC_REGFILE_LOG2_DEEP-1:0]   write_addr_i,
    input  logic [NUM_WR_PORTS*PROC_DATA_WIDTH-1:0]          write_data_i,
    input  logic [NUM_RD_PORTS*PROC_REGFILE_LOG2_DEEP-1:0]   read_addr_i,
    output logic [NUM_RD_PORTS*PROC_DATA_WIDTH-1:0]          read_data_o,
    output logic [NUM_RD_PORTS-1:0]                          read_pending_o,
    input  logic                                             reserve_en_i,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0]                reserve_addr_i,
    input  logic                                             clear_req_i,
    output logic                                             busy_o,
    output logic                                             dbg_state_o
);

    localparam int AW = PROC_REGFILE_LOG2_DEEP;
    localparam int DW = PROC_DATA_WIDTH;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic [DW-1:0]            regs_q [NUM_REGISTERS];
    logic [DW-1:0]            regs_d [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] pending_q, pending_d;

    logic [AW-1:0]            wa [NUM_WR_PORTS];
    logic [DW-1:0]            wd [NUM_WR_PORTS];
    logic [AW-1:0]            ra [NUM_RD_PORTS];
    logic [NUM_WR_PORTS-1:0]  wr_ok;
    logic                     busy;

    assign busy        = (state_q == CLEAR);
    assign busy_o      = busy;
    assign dbg_state_o = state_q;

    // A port "commits" only when it would really update the array; this same
    // qualifier drives storage, pending clears and read bypass.
    always_comb begin
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            wa[k]    = write_addr_i[k*AW +: AW];
            wd[k]    = write_data_i[k*DW +: DW];
            wr_ok[k] = write_en_i[k] && !busy
                       && (32'(wa[k]) < NUM_REGISTERS)
                       && !((ZERO_REG != 0) && (wa[k] == '0));
        end
        for (int j = 0; j < NUM_RD_PORTS; j++) begin
            ra[j] = read_addr_i[j*AW +: AW];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        regs_d    = regs_q;
        pending_d = pending_q;
        if (state_q == CLEAR) begin
            for (int r = 0; r < NUM_REGISTERS; r++) begin
                if (idx_q == AW'(r)) begin
                    regs_d[r]    = '0;
                    pending_d[r] = 1'b0;
                end
            end
            if (32'(idx_q) == NUM_REGISTERS - 1) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            // Ascending port order lets the highest-index writer win.
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                for (int r = 0; r < NUM_REGISTERS; r++) begin
                    if (wr_ok[k] && (wa[k] == AW'(r))) begin
                        regs_d[r]    = wd[k];
                        pending_d[r] = 1'b0;
                    end
                end
            end
            // Reserve applied after writes so a same-cycle reserve sticks.
            if (reserve_en_i) begin
                for (int r = 0; r < NUM_REGISTERS; r++) begin
                    if (reserve_addr_i == AW'(r)) begin
                        pending_d[r] = 1'b1;
                    end
                end
            end
            if (clear_req_i) begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        end
    end

    always_comb begin
        read_data_o    = '0;
        read_pending_o = '0;
        for (int j = 0; j < NUM_RD_PORTS; j++) begin
            if (!busy && !((ZERO_REG != 0) && (ra[j] == '0))) begin
                for (int r = 0; r < NUM_REGISTERS; r++) begin
                    if (ra[j] == AW'(r)) begin
                        read_data_o[j*DW +: DW] = regs_q[r];
                        read_pending_o[j]       = pending_q[r];
                    end
                end
                for (int k = 0; k < NUM_WR_PORTS; k++) begin
                    if (wr_ok[k] && (wa[k] == ra[j])) begin
                        read_data_o[j*DW +: DW] = wd[k];
                        read_pending_o[j]       = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            idx_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    // Array contents are only defined after the sweep, so no reset here.
    always_ff @(posedge clk_i) begin
        regs_q <= regs_d;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized bench for register_file_mp against an array-based reference
// model, plus directed cases for bypass, zero register, reservations and clear.
module tb_register_file_mp;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int N  = 32;
    localparam int NW = 2;
    localparam int NR = 4;
    localparam bit ZR = 1'b1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NW-1:0]    write_en_i;
    logic [NW*AW-1:0] write_addr_i;
    logic [NW*DW-1:0] write_data_i;
    logic [NR*AW-1:0] read_addr_i;
    logic [NR*DW-1:0] read_data_o;
    logic [NR-1:0]    read_pending_o;
    logic             reserve_en_i;
    logic [AW-1:0]    reserve_addr_i;
    logic             clear_req_i;
    logic             busy_o;
    logic             dbg_state_o;

    register_file_mp #(
        .PROC_DATA_WIDTH(DW), .PROC_REGFILE_LOG2_DEEP(AW), .NUM_REGISTERS(N),
        .NUM_WR_PORTS(NW), .NUM_RD_PORTS(NR), .ZERO_REG(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .write_en_i(write_en_i), .write_addr_i(write_addr_i), .write_data_i(write_data_i),
        .read_addr_i(read_addr_i), .read_data_o(read_data_o), .read_pending_o(read_pending_o),
        .reserve_en_i(reserve_en_i), .reserve_addr_i(reserve_addr_i),
        .clear_req_i(clear_req_i), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: plain arrays plus a count of remaining sweep cycles.
    logic [DW-1:0] m_mem [N];
    bit            m_pend [N];
    int            m_busy_left;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wr_addr(int k);
        return int'(write_addr_i[k*AW +: AW]);
    endfunction

    function automatic bit model_commit(int k);
        int a = wr_addr(k);
        return write_en_i[k] && (m_busy_left == 0) && (a < N) && !(ZR && a == 0);
    endfunction

    function automatic logic [DW-1:0] exp_data(int j);
        int a = int'(read_addr_i[j*AW +: AW]);
        logic [DW-1:0] v;
        if (m_busy_left > 0 || (ZR && a == 0) || a >= N) return '0;
        v = m_mem[a];
        for (int k = 0; k < NW; k++)
            if (model_commit(k) && wr_addr(k) == a) v = write_data_i[k*DW +: DW];
        return v;
    endfunction

    function automatic bit exp_pend(int j);
        int a = int'(read_addr_i[j*AW +: AW]);
        if (m_busy_left > 0 || (ZR && a == 0) || a >= N) return 1'b0;
        for (int k = 0; k < NW; k++)
            if (model_commit(k) && wr_addr(k) == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_reset();
        m_busy_left = N;
        for (int r = 0; r < N; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (rst_i) begin
            model_reset();
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (model_commit(k)) begin
                    m_mem[wr_addr(k)]  = write_data_i[k*DW +: DW];
                    m_pend[wr_addr(k)] = 1'b0;
                end
            end
            if (reserve_en_i && int'(reserve_addr_i) < N) m_pend[int'(reserve_addr_i)] = 1'b1;
            if (clear_req_i) model_reset();
        end
    endtask

    task automatic check_outputs();
        for (int j = 0; j < NR; j++) begin
            check_eq($sformatf("rd_data[%0d]", j), 32'(read_data_o[j*DW +: DW]), 32'(exp_data(j)));
            check_eq($sformatf("rd_pend[%0d]", j), 32'(read_pending_o[j]), 32'(exp_pend(j)));
        end
        check_eq("busy", 32'(busy_o), 32'(m_busy_left > 0));
        check_eq("dbg_state", 32'(dbg_state_o), 32'(m_busy_left > 0));
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic run_cycle();
        #1;
        check_outputs();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
    endtask

    task automatic set_wr(input int k, input bit en, input int a, input logic [DW-1:0] d);
        write_en_i[k]           = en;
        write_addr_i[k*AW +: AW] = AW'(a);
        write_data_i[k*DW +: DW] = d;
    endtask

    task automatic set_rd(input int j, input int a);
        read_addr_i[j*AW +: AW] = AW'(a);
    endtask

    task automatic idle_inputs();
        write_en_i     = '0;
        write_addr_i   = '0;
        write_data_i   = '0;
        read_addr_i    = '0;
        reserve_en_i   = 1'b0;
        reserve_addr_i = '0;
        clear_req_i    = 1'b0;
    endtask

    task automatic count_sweep(input string tag);
        int n = 0;
        while (busy_o && n < 100) begin
            run_cycle();
            n++;
        end
        check_eq(tag, 32'(n), 32'(N));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk_i);
        for (int j = 0; j < NR; j++) set_rd(j, j + 3);
        run_cycle();
        run_cycle();
        rst_i = 1'b0;
        count_sweep("reset_sweep_len");
        for (int a = 0; a < N; a += NR) begin
            for (int j = 0; j < NR; j++) set_rd(j, a + j);
            #1;
            for (int j = 0; j < NR; j++) check_eq("post_reset_zero", 32'(read_data_o[j*DW +: DW]), 32'h0);
            run_cycle();
        end

        // Same-cycle writes to one address: highest port wins, bypassed.
        idle_inputs();
        set_wr(0, 1, 5, 16'h1111);
        set_wr(1, 1, 5, 16'h2222);
        set_rd(0, 5);
        #1 check_eq("bypass_5", 32'(read_data_o[DW-1:0]), 32'h2222);
        run_cycle();
        idle_inputs();
        set_rd(0, 5);
        #1 check_eq("stored_5", 32'(read_data_o[DW-1:0]), 32'h2222);
        run_cycle();

        // Register 0 is hardwired.
        set_wr(0, 1, 0, 16'hBEEF);
        set_rd(1, 0);
        #1 check_eq("zero_reg_byp", 32'(read_data_o[DW +: DW]), 32'h0);
        check_eq("zero_reg_pend", 32'(read_pending_o[1]), 32'h0);
        run_cycle();
        idle_inputs();
        set_rd(1, 0);
        #1 check_eq("zero_reg_data", 32'(read_data_o[DW +: DW]), 32'h0);
        run_cycle();

        // Reservation then satisfying write.
        reserve_en_i   = 1'b1;
        reserve_addr_i = AW'(7);
        run_cycle();
        idle_inputs();
        set_rd(2, 7);
        #1 check_eq("resv_pend_7", 32'(read_pending_o[2]), 32'h1);
        run_cycle();
        set_wr(1, 1, 7, 16'h00AA);
        set_rd(2, 7);
        #1 check_eq("resv_wr_pend", 32'(read_pending_o[2]), 32'h0);
        check_eq("resv_wr_data", 32'(read_data_o[2*DW +: DW]), 32'h00AA);
        run_cycle();
        idle_inputs();
        set_rd(2, 7);
        #1 check_eq("resv_after_pend", 32'(read_pending_o[2]), 32'h0);
        run_cycle();

        // Fill 1..31, then clear sweep while attempting writes and reserves.
        for (int a = 1; a < N; a += 2) begin
            set_wr(0, 1, a, 16'(a * 16'h0101));
            set_wr(1, (a + 1) < N, a + 1, 16'(16'hA000 + a));
            set_rd(0, a);
            run_cycle();
        end
        idle_inputs();
        clear_req_i = 1'b1;
        run_cycle();
        clear_req_i = 1'b0;
        set_wr(0, 1, 3, 16'hDEAD);
        reserve_en_i   = 1'b1;
        reserve_addr_i = AW'(9);
        count_sweep("clear_sweep_len");
        idle_inputs();
        for (int a = 0; a < N; a += NR) begin
            for (int j = 0; j < NR; j++) set_rd(j, a + j);
            #1;
            for (int j = 0; j < NR; j++) begin
                check_eq("post_clear_zero", 32'(read_data_o[j*DW +: DW]), 32'h0);
                check_eq("post_clear_pend", 32'(read_pending_o[j]), 32'h0);
            end
            run_cycle();
        end

        // Reset mid-sweep restarts from index 0.
        clear_req_i = 1'b1;
        run_cycle();
        clear_req_i = 1'b0;
        for (int i = 0; i < 10; i++) run_cycle();
        rst_i = 1'b1;
        model_reset();
        #1 check_eq("mid_reset_busy", 32'(busy_o), 32'h1);
        run_cycle();
        run_cycle();
        rst_i = 1'b0;
        count_sweep("restart_sweep_len");

        // Randomized traffic with address collisions favoured.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NW; k++)
                set_wr(k, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, N - 1),
                       16'($urandom));
            reserve_en_i   = ($urandom_range(0, 2) == 0);
            reserve_addr_i = AW'($urandom_range(0, 7));
            clear_req_i    = ($urandom_range(0, 149) == 0);
            for (int j = 0; j < NR; j++)
                set_rd(j, $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, N - 1));
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter PROC_DATA_WIDTH, default 16, bits per register.
REQ-002 SHALL have parameter PROC_REGFILE_LOG2_DEEP, default 5, address width.
REQ-003 SHALL have parameter NUM_REGISTERS, default 32, entries; NUM_REGISTERS <= 2**PROC_REGFILE_LOG2_DEEP.
REQ-004 SHALL have parameter NUM_WR_PORTS, default 2, write ports, range 1..4.
REQ-005 SHALL have parameter NUM_RD_PORTS, default 4, read ports, range 1..8.
REQ-006 SHALL have parameter ZERO_REG, default 1; 1 hardwires register 0 to zero.
REQ-007 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-009 SHALL have port write_en_i, input, NUM_WR_PORTS, per-port write enable.
REQ-010 SHALL have port write_addr_i, input, NUM_WR_PORTS*LOG2_DEEP, flattened addresses, port k at slice k.
REQ-011 SHALL have port write_data_i, input, NUM_WR_PORTS*DATA_WIDTH, flattened write data.
REQ-012 SHALL have port read_addr_i, input, NUM_RD_PORTS*LOG2_DEEP, flattened read addresses.
REQ-013 SHALL have port read_data_o, output, NUM_RD_PORTS*DATA_WIDTH, flattened read data.
REQ-014 SHALL have port read_pending_o, output, NUM_RD_PORTS, 1 = addressed register has outstanding reservation.
REQ-015 SHALL have port reserve_en_i, input, 1, mark reserve_addr_i pending.
REQ-016 SHALL have port reserve_addr_i, input, LOG2_DEEP, register to reserve.
REQ-017 SHALL have port clear_req_i, input, 1, pulse to start full-file zeroing sweep.
REQ-018 SHALL have port busy_o, output, 1, 1 while clear sweep in progress.

Function
REQ-019 Write SHALL commit on rising clk_i when write_en_i[k]=1, busy_o=0, address < NUM_REGISTERS, and not (ZERO_REG=1 and address=0).
REQ-020 Same-cycle writes to one address SHALL resolve to highest-index port; lower ports dropped.
REQ-021 Reads SHALL be combinational; read port j returns: 0 if busy_o=1; else 0 if ZERO_REG=1 and address 0; else 0 if address >= NUM_REGISTERS; else bypassed write data of highest-index enabled port writing that address; else stored value.
REQ-022 Pending bit per register SHALL set on reserve_en_i and clear on a committed write to that register; same-cycle reserve and write to one register leaves bit set.
REQ-023 read_pending_o[j] SHALL be 0 for register 0 when ZERO_REG=1, for out-of-range addresses, and while busy_o=1; a same-cycle write to the address forces it 0 (bypass satisfies hazard).
REQ-024 Clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clear_req_i=1; CLEAR zeroes entry idx and its pending bit each cycle, idx 0..NUM_REGISTERS-1, then ->IDLE.
REQ-025 Clear sweep SHALL take exactly NUM_REGISTERS cycles; busy_o=1 from the cycle after the request through the final clearing edge.
REQ-026 In CLEAR, write_en_i, reserve_en_i and clear_req_i SHALL be ignored (no restart, no queuing).
REQ-027 Address comparisons SHALL use full LOG2_DEEP bits; no wrap-around of out-of-range addresses.

Reset
REQ-028 rst_i=1 SHALL asynchronously force FSM to CLEAR, idx to 0, busy_o to 1, all pending bits to 0.
REQ-029 After rst_i deasserts, sweep SHALL run NUM_REGISTERS cycles, then busy_o=0; array contents are defined only after sweep.
REQ-030 rst_i asserted mid-sweep SHALL restart sweep from idx 0.

Verification
REQ-031 Reset then NUM_REGISTERS cycles idle -> busy_o falls on cycle 32; all read ports return 0x0000.
REQ-032 Port0 and port1 write addr 5 (0x1111, 0x2222) same cycle; read port 0 at addr 5 -> 0x2222 in cycle (bypass) and after.
REQ-033 Write 0xBEEF to addr 0 with ZERO_REG=1 -> read addr 0 returns 0x0000, read_pending_o 0.
REQ-034 Reserve addr 7; read addr 7 -> pending 1; next cycle write 0x00AA to 7 -> pending 0 that cycle, data 0x00AA.
REQ-035 Load regs 1..31, pulse clear_req_i, write during sweep -> busy_o high 32 cycles, write dropped, all reads 0 after.
REQ-036 Assert rst_i at sweep idx 10 -> busy_o stays 1, sweep restarts, busy_o falls 32 cycles after deassert.
